// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0: what a faulting fetch returns
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ErrOk         = 2'b00,
    ErrMisaligned = 2'b01,
    ErrOutOfRange = 2'b10
  } rsp_err_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    rsp_err_e        err;
  } rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO with an occupancy count. The head word reads as zero when empty.
module rsp_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign pop_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipeline feeding an in-order response queue.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic [1:0]                     rsp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned FDEPTH = LATENCY + 1;
  localparam int unsigned OW    = $clog2(LATENCY + 2);
  localparam int unsigned CW    = $clog2(FDEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [OW-1:0]   outstanding_q;
  logic            ready_en_q;
  logic            accept, xfer;
  rsp_t            acc_rsp, push_data, head;
  logic            push;
  logic [CW-1:0]   fifo_count;

  assign accept = req_valid && req_ready;
  assign xfer   = rsp_valid && rsp_ready;

  // Outstanding covers the pipeline plus the queue, so capping it at the
  // queue depth guarantees the queue cannot overflow.
  assign req_ready = ready_en_q && (outstanding_q < OW'(LATENCY + 1)) && !load_en;

  // Program-load port; memory deliberately survives reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Classify the fetch and read the word at the accept edge.
  always_comb begin
    acc_rsp.instr = NOP;
    acc_rsp.err   = ErrOk;
    if (req_addr[1:0] != 2'b00) begin
      acc_rsp.err = ErrMisaligned;
    end else if (req_addr[XLEN-1:AW+2] != '0) begin
      acc_rsp.err = ErrOutOfRange;
    end else begin
      acc_rsp.instr = mem_q[req_addr[AW+1:2]];
    end
  end

  // Holds ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  // Requests accepted but not yet handed to the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= '0;
    end else if (accept && !xfer) begin
      outstanding_q <= outstanding_q + OW'(1);
    end else if (!accept && xfer) begin
      outstanding_q <= outstanding_q - OW'(1);
    end
  end

  // The queue write itself adds one cycle, so LATENCY-1 stages sit in front of it.
  if (LATENCY == 1) begin : g_direct
    assign push      = accept;
    assign push_data = acc_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    rsp_t               data_q [LATENCY-1];

    // Shift the accepted response toward the queue.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) data_q[i] <= '0;
      end else begin
        vld_q[0]  <= accept;
        data_q[0] <= acc_rsp;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign push      = vld_q[LATENCY-2];
    assign push_data = data_q[LATENCY-2];
  end

  rsp_fifo #(
    .DEPTH (FDEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_instr = head.instr;
  assign rsp_err   = head.err;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, giving the instruction-memory size in 32-bit words, a power of two.
REQ-002 The module SHALL have parameter LATENCY, default 2, legal range 1..4, giving the cycles from request accept to response valid.
REQ-003 The module SHALL have port clk, input, 1 bit, the clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The module SHALL have port req_valid, input, 1 bit, meaning a fetch request is presented.
REQ-006 The module SHALL have port req_ready, output, 1 bit, meaning a request can be accepted.
REQ-007 The module SHALL have port req_addr, input, 32 bits, the byte address of the fetch (the PC value).
REQ-008 The module SHALL have port rsp_valid, output, 1 bit, meaning a response is presented.
REQ-009 The module SHALL have port rsp_ready, input, 1 bit, meaning the consumer takes the response.
REQ-010 The module SHALL have port rsp_instr, output, 32 bits, the instruction word.
REQ-011 The module SHALL have port rsp_err, output, 2 bits, with encodings 00 OK, 01 MISALIGNED, 10 OUT_OF_RANGE.
REQ-012 The module SHALL have port load_en, input, 1 bit, a program-load write strobe.
REQ-013 The module SHALL have port load_addr, input, clog2(DEPTH_WORDS) bits, the word index to load.
REQ-014 The module SHALL have port load_data, input, 32 bits, the word to load.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; a response SHALL transfer on an edge where rsp_valid and rsp_ready are both 1.
REQ-016 Responses SHALL be returned in accept order, exactly one response per accepted request.
REQ-017 An accepted request SHALL become visible on rsp_valid exactly LATENCY cycles after accept when no older response is pending; otherwise it SHALL be queued behind the older responses.
REQ-018 An outstanding counter SHALL track requests accepted but not yet transferred: +1 on accept, -1 on transfer, unchanged when both occur in the same cycle.
REQ-019 req_ready SHALL be 1 iff outstanding < LATENCY+1 and load_en is 0; it SHALL be a function of registered state and load_en only, with no combinational path from rsp_ready.
REQ-020 An internal response FIFO of depth LATENCY+1 SHALL absorb responses; it SHALL never overflow because of REQ-019.
REQ-021 With rsp_ready held at 1, the block SHALL sustain one accept per cycle indefinitely.
REQ-022 While rsp_valid is 1 and rsp_ready is 0, rsp_instr and rsp_err SHALL remain stable.
REQ-023 A request with req_addr[1:0] != 0 SHALL respond with rsp_err = 01 and rsp_instr = 0x00000013 (NOP).
REQ-024 An aligned request with req_addr[31:2] >= DEPTH_WORDS SHALL respond with rsp_err = 10 and rsp_instr = NOP; when both error conditions hold, MISALIGNED SHALL take priority.
REQ-025 An aligned, in-range request SHALL respond with rsp_err = 00 and rsp_instr = mem[req_addr[31:2]] as sampled at the accept edge.
REQ-026 load_en SHALL write load_data to mem[load_addr] on the rising edge; loads SHALL have priority over new accepts (per REQ-019), and in-flight reads SHALL complete normally.

Reset
REQ-027 While reset is asserted, rsp_valid, rsp_instr, rsp_err, req_ready, the outstanding counter, the pipeline and the FIFO SHALL all be 0 or empty.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight and queued responses, and SHALL NOT alter memory contents.
REQ-029 req_ready SHALL first be able to assert on the first rising edge after reset deasserts.

Structure
REQ-030 Package imem_pkg SHALL hold the rsp_err enum typedef, the NOP constant 0x00000013 and the XLEN=32 constant.
REQ-031 The response queue SHALL be a sub-module rsp_fifo, a parameterised synchronous FIFO with count output; the latency pipeline and memory SHALL live in imem_responder.

Verification
REQ-032 Load 0xDEADBEEF at word 4; request addr 0x10 with rsp_ready=1 -> rsp_valid exactly 2 cycles later, rsp_instr=0xDEADBEEF, rsp_err=00.
REQ-033 Back-to-back requests to 0x0, 0x4, 0x8 with rsp_ready=1 -> req_ready stays 1 and responses arrive on 3 consecutive cycles, in order.
REQ-034 Hold rsp_ready=0 and issue requests -> exactly 3 accepted, then req_ready=0; responses stay stable; raising rsp_ready drains all 3 in order and req_ready returns to 1.
REQ-035 Request addr 0x6 -> err=01 with instr=NOP; addr 0x400 (DEPTH_WORDS=256) -> err=10 with instr=NOP; addr 0x402 -> err=01.
REQ-036 Assert reset with 2 requests outstanding -> rsp_valid=0 immediately and no stale response after release; previously loaded memory is still readable.
REQ-037 Assert load_en while req_valid=1 -> req_ready=0 for that cycle and no request is accepted; the next cycle accepts and reads the newly loaded data.
